// File: rtl/second_chance_bucket_writer_pkg.sv
// Shared types and helpers for the second-chance bucket writer.
package second_chance_bucket_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  function automatic int hand_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest clear bit among the low n bits of v (0 when none is clear).
  function automatic int lowest_zero_idx(input logic [31:0] v, input int n);
    int          idx;
    logic [31:0] s;
    idx = 0;
    for (int i = n - 1; i >= 0; i--) begin
      s = v >> i;
      if (!s[0]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/second_chance_bucket_writer_finder.sv
// Lowest empty slot of a bucket as a one-hot vector, plus an any-free flag.
module first_free_slot_finder
  import second_chance_bucket_writer_pkg::*;
#(
  parameter int BUCKET_SIZE = 4
) (
  input  logic [BUCKET_SIZE-1:0] valid_bits_i,
  output logic [BUCKET_SIZE-1:0] free_oh_o,
  output logic                   any_free_o
);

  int idx;

  always_comb begin
    any_free_o = ~&valid_bits_i;
    idx        = lowest_zero_idx(32'(valid_bits_i), BUCKET_SIZE);
    free_oh_o  = '0;
    for (int i = 0; i < BUCKET_SIZE; i++)
      free_oh_o[i] = any_free_o && (idx == i);
  end

endmodule

// File: rtl/second_chance_bucket_writer.sv
// Insert-side slot picker: free slot first, otherwise a second-chance (clock) victim.
module second_chance_bucket_writer
  import second_chance_bucket_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BUCKET_SIZE = 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH-1:0]                   in_data,
  input  logic [BUCKET_SIZE-1:0]                  in_valid_bits,
  input  logic [BUCKET_SIZE-1:0]                  in_ref_bits,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [BUCKET_SIZE-1:0]                  out_sel,
  output logic [BUCKET_SIZE-1:0][DATA_WIDTH-1:0]  out_data_vec,
  output logic [BUCKET_SIZE-1:0]                  out_ref_bits,
  output logic                                    out_evict
);

  localparam int HW = hand_w(BUCKET_SIZE);

  state_e                                 state_q, state_d;
  logic [HW-1:0]                          hand_q, hand_d, hand_nxt;
  logic [DATA_WIDTH-1:0]                  data_q, data_d;
  logic [BUCKET_SIZE-1:0]                 ref_q, ref_d;
  logic [BUCKET_SIZE-1:0]                 sel_q, sel_d;
  logic [BUCKET_SIZE-1:0][DATA_WIDTH-1:0] vec_q, vec_d;
  logic [BUCKET_SIZE-1:0]                 oref_q, oref_d;
  logic                                   evict_q, evict_d;

  logic [BUCKET_SIZE-1:0]                 free_oh, hand_oh, pick_oh;
  logic                                   any_free;
  logic [DATA_WIDTH-1:0]                  pick_data;
  logic [BUCKET_SIZE-1:0][DATA_WIDTH-1:0] steer_vec;

  first_free_slot_finder #(.BUCKET_SIZE(BUCKET_SIZE)) u_finder (
    .valid_bits_i (in_valid_bits),
    .free_oh_o    (free_oh),
    .any_free_o   (any_free)
  );

  assign hand_nxt = (hand_q == HW'(BUCKET_SIZE - 1)) ? '0 : hand_q + 1'b1;

  // Lane steering is shared: free-slot pick from IDLE, victim pick from SCAN.
  always_comb begin
    hand_oh = '0;
    for (int i = 0; i < BUCKET_SIZE; i++)
      hand_oh[i] = (hand_q == HW'(i));
    pick_oh   = (state_q == S_IDLE) ? free_oh : hand_oh;
    pick_data = (state_q == S_IDLE) ? in_data : data_q;
    steer_vec = '0;
    for (int i = 0; i < BUCKET_SIZE; i++)
      steer_vec[i] = pick_oh[i] ? pick_data : '0;
  end

  always_comb begin
    state_d = state_q;
    hand_d  = hand_q;
    data_d  = data_q;
    ref_d   = ref_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    oref_d  = oref_q;
    evict_d = evict_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          ref_d  = in_ref_bits;
          if (any_free) begin
            sel_d   = free_oh;
            vec_d   = steer_vec;
            oref_d  = in_ref_bits | free_oh;
            evict_d = 1'b0;
            state_d = S_OUT;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        hand_d = hand_nxt;
        if (|(ref_q & hand_oh)) begin
          ref_d = ref_q & ~hand_oh;
        end else begin
          sel_d   = hand_oh;
          vec_d   = steer_vec;
          oref_d  = ref_q | hand_oh;
          evict_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          sel_d   = '0;
          vec_d   = '0;
          oref_d  = '0;
          evict_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hand_q  <= '0;
      data_q  <= '0;
      ref_q   <= '0;
      sel_q   <= '0;
      vec_q   <= '0;
      oref_q  <= '0;
      evict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hand_q  <= hand_d;
      data_q  <= data_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      oref_q  <= oref_d;
      evict_q <= evict_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_OUT);
  assign out_sel      = sel_q;
  assign out_data_vec = vec_q;
  assign out_ref_bits = oref_q;
  assign out_evict    = evict_q;

endmodule

// File: tb/tb_second_chance_bucket_writer.sv
// Scoreboard bench for the second-chance bucket writer (BUCKET_SIZE=4, DATA_WIDTH=32).
module tb_second_chance_bucket_writer;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [3:0]       in_valid_bits;
  logic [3:0]       in_ref_bits;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_sel;
  logic [3:0][31:0] out_data_vec;
  logic [3:0]       out_ref_bits;
  logic             out_evict;

  int pass_cnt = 0;
  int total_cnt = 0;
  int hand_m = 0;

  typedef struct {
    int          lat;
    logic [3:0]  sel;
    logic [3:0]  rf;
    logic        ev;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  second_chance_bucket_writer #(.DATA_WIDTH(32), .BUCKET_SIZE(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_valid_bits(in_valid_bits),
    .in_ref_bits  (in_ref_bits),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .out_data_vec (out_data_vec),
    .out_ref_bits (out_ref_bits),
    .out_evict    (out_evict)
  );

  // Reference model of slot choice; pushes the expectation for one insert.
  task automatic push_expect(input logic [3:0] vb, input logic [3:0] rb, input logic [31:0] d);
    exp_t e;
    logic [3:0] r;
    int idx, k;
    r = rb;
    if (vb != 4'hF) begin
      idx = 3;
      for (int i = 3; i >= 0; i--) if (!vb[i]) idx = i;
      e.lat = 1;
      e.ev  = 1'b0;
    end else begin
      k = 0;
      while (r[hand_m]) begin
        r[hand_m] = 1'b0;
        hand_m = (hand_m + 1) % 4;
        k++;
      end
      idx = hand_m;
      hand_m = (hand_m + 1) % 4;
      e.lat = 2 + k;
      e.ev  = 1'b1;
    end
    e.sel = 4'(1 << idx);
    e.rf  = r | e.sel;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic do_insert(input string nm, input logic [3:0] vb, input logic [3:0] rb,
                           input logic [31:0] d, input int hold);
    exp_t e;
    int c;
    logic [3:0] s_sel, s_rf;
    logic [3:0][31:0] s_vec;
    logic s_ev;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_idle: got %b want 1", nm, in_ready);
    else pass_cnt++;
    push_expect(vb, rb, d);
    in_valid = 1'b1; in_data = d; in_valid_bits = vb; in_ref_bits = rb;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = $urandom; in_ref_bits = 4'($urandom);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (out_valid !== 1'b1 && c < 20);
    e = sb.pop_front();
    total_cnt++;
    if (c !== e.lat) $display("FAIL %s latency: got %0d want %0d", nm, c, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (out_sel !== e.sel) $display("FAIL %s out_sel: got %b want %b", nm, out_sel, e.sel);
    else pass_cnt++;
    total_cnt++;
    if (out_ref_bits !== e.rf) $display("FAIL %s out_ref_bits: got %b want %b", nm, out_ref_bits, e.rf);
    else pass_cnt++;
    total_cnt++;
    if (out_evict !== e.ev) $display("FAIL %s out_evict: got %b want %b", nm, out_evict, e.ev);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_data_vec[i] !== (e.sel[i] ? e.d : 32'h0))
        $display("FAIL %s lane%0d: got %h want %h", nm, i, out_data_vec[i], e.sel[i] ? e.d : 32'h0);
      else pass_cnt++;
    end
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL %s in_ready_busy: got %b want 0", nm, in_ready);
    else pass_cnt++;
    s_sel = out_sel; s_rf = out_ref_bits; s_vec = out_data_vec; s_ev = out_evict;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 32'hBAD0_0000 + h; in_valid_bits = 4'b0000;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_sel !== s_sel || out_ref_bits !== s_rf ||
          out_data_vec !== s_vec || out_evict !== s_ev || in_ready !== 1'b0)
        $display("FAIL %s hold%0d: got v=%b sel=%b ref=%b ev=%b rdy=%b want v=1 sel=%b ref=%b ev=%b rdy=0",
                 nm, h, out_valid, out_sel, out_ref_bits, out_evict, in_ready, s_sel, s_rf, s_ev);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sel !== 4'b0)
      $display("FAIL %s after_write: got v=%b rdy=%b sel=%b want v=0 rdy=1 sel=0000",
               nm, out_valid, in_ready, out_sel);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_valid_bits = '0; in_ref_bits = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_sel !== 4'b0 || out_data_vec !== '0 ||
        out_ref_bits !== 4'b0 || out_evict !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got v=%b sel=%b ref=%b ev=%b rdy=%b want 0/0/0/0/1",
               out_valid, out_sel, out_ref_bits, out_evict, in_ready);
    else pass_cnt++;
    hand_m = 0;
  endtask

  task automatic test_free_slot();
    do_insert("free_slot", 4'b1011, 4'b0000, 32'hDEADBEEF, 0);
  endtask

  task automatic test_all_refs();
    do_insert("all_refs", 4'b1111, 4'b1111, 32'h1234_5678, 0);
  endtask

  task automatic test_back_to_back();
    do_insert("b2b_a", 4'b1111, 4'b0000, 32'hA5A5_0001, 0);
    do_insert("b2b_b", 4'b1111, 4'b0000, 32'hA5A5_0002, 0);
  endtask

  task automatic test_wrap();
    do_insert("wrap", 4'b1111, 4'b1000, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_backpressure();
    do_insert("backpressure", 4'b0111, 4'b0110, 32'h0BAD_CAFE, 5);
  endtask

  task automatic test_reset_in_scan();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h5555_AAAA; in_valid_bits = 4'b1111; in_ref_bits = 4'b1111;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    hand_m = 0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_sel !== 4'b0 || out_data_vec !== '0 ||
        out_ref_bits !== 4'b0 || out_evict !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_scan_state: got v=%b sel=%b ref=%b ev=%b rdy=%b want 0/0/0/0/1",
               out_valid, out_sel, out_ref_bits, out_evict, in_ready);
    else pass_cnt++;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_scan_no_write: got %0d valid cycles want 0", seen);
    else pass_cnt++;
    do_insert("post_reset_hand0", 4'b1111, 4'b0000, 32'h0000_BEEF, 0);
  endtask

  initial begin
    test_reset();
    test_free_slot();
    test_all_refs();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_reset_in_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
